pc_fetch: RTL and testbench

Instruction-fetch stage that drives the IF/ID pipeline register: keeps the program counter, issues word reads to the instruction memory over a req/ack handshake, and presents {if_pc, if_inst, if_valid} to the IF/ID register each cycle. It honours pipeline stalls from control through a one-entry skid buffer. It applies ID-stage branch redirects, squashing any in-flight fetch.

---
 rtl/pc_fetch_pkg.sv | 28 ++
 rtl/pc_fetch_if.sv | 24 ++
 rtl/fetch_skid_buf.sv | 31 +++
 rtl/pc_fetch.sv | 146 ++++++++++++++
 tb/tb_pc_fetch.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared widths, constants, state encoding and pc helpers for the fetch stage
package pc_fetch_pkg;

    localparam int inst_addr_bus = 32;
    localparam int inst_bus      = 32;

    localparam logic                     rst_enable = 1'b1;
    localparam logic [inst_bus-1:0]      zero_v     = '0;
    localparam logic [inst_addr_bus-1:0] inst_bytes = 32'd4;

    typedef enum logic [1:0] {
        fetch_idle     = 2'b00,
        fetch_req      = 2'b01,
        fetch_squash   = 2'b10,
        fetch_buffered = 2'b11
    } fetch_state_e;

    // Sequential successor; wraps modulo 2^32 by construction.
    function automatic logic [inst_addr_bus-1:0] next_pc(input logic [inst_addr_bus-1:0] pc);
        return pc + inst_bytes;
    endfunction

    // Redirect targets are forced onto a word boundary.
    function automatic logic [inst_addr_bus-1:0] word_align(input logic [inst_addr_bus-1:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - instruction memory req/ack bus between fetch stage and memory
interface pc_fetch_if;
    import pc_fetch_pkg::*;

    logic                     imem_req;
    logic [inst_addr_bus-1:0] imem_addr;
    logic                     imem_ack;
    logic [inst_bus-1:0]      imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {pc, inst} holding register for a fetch that arrives during a stall
module fetch_skid_buf
    import pc_fetch_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     clear,
    input  logic [inst_addr_bus-1:0] load_pc,
    input  logic [inst_bus-1:0]      load_inst,
    output logic                     full,
    output logic [inst_addr_bus-1:0] pc,
    output logic [inst_bus-1:0]      inst
);

    // Capture on load, empty on clear; clear wins so a redirect always drops stale data.
    always_ff @(posedge clk) begin
        if (rst == rst_enable) begin
            full <= 1'b0;
            pc   <= zero_v;
            inst <= zero_v;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            pc   <= load_pc;
            inst <= load_inst;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - instruction fetch stage feeding the IF/ID register with stall skid and branch squash
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [inst_addr_bus-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     branch_flag,
    input  logic [inst_addr_bus-1:0] branch_target,
    pc_fetch_if.master               imem,
    output logic [inst_addr_bus-1:0] if_pc,
    output logic [inst_bus-1:0]      if_inst,
    output logic                     if_valid
);

    fetch_state_e             state;
    logic [inst_addr_bus-1:0] pc;
    logic [inst_addr_bus-1:0] req_addr;
    logic                     req;

    logic                     ack;
    logic                     br;
    logic                     slot_free;
    logic [inst_addr_bus-1:0] target;

    logic                     skid_load;
    logic                     skid_clear;
    logic                     skid_full;
    logic [inst_addr_bus-1:0] skid_pc;
    logic [inst_bus-1:0]      skid_inst;

    assign imem.imem_req  = req;
    assign imem.imem_addr = req_addr;

    // ack only matters in FETCH/SQUASH, where req is known to be high
    assign ack       = imem.imem_ack;
    assign br        = branch_flag && !stall;
    assign slot_free = !stall || !if_valid;
    assign target    = word_align(branch_target);

    // Skid buffer control: fill when an ack lands on an occupied, stalled slot; drain or drop otherwise.
    always_comb begin
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (state == fetch_req && ack && !br && !slot_free) begin
            skid_load = 1'b1;
        end
        if (br || (state == fetch_buffered && !stall)) begin
            skid_clear = 1'b1;
        end
    end

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_pc   (req_addr),
        .load_inst (imem.imem_rdata),
        .full      (skid_full),
        .pc        (skid_pc),
        .inst      (skid_inst)
    );

    // Fetch FSM: pc, outstanding request and the IF/ID slot all advance together here.
    // In SQUASH, pc already holds the redirect target while req_addr keeps the abandoned address.
    always_ff @(posedge clk) begin
        if (rst == rst_enable) begin
            state    <= fetch_idle;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            req      <= 1'b0;
            if_pc    <= zero_v;
            if_inst  <= zero_v;
            if_valid <= 1'b0;
        end else begin
            case (state)
                fetch_idle: begin
                    state <= fetch_req;
                    req   <= 1'b1;
                    if (br) begin
                        pc       <= target;
                        req_addr <= target;
                    end
                end
                fetch_req: begin
                    if (br) begin
                        pc       <= target;
                        if_valid <= 1'b0;
                        if (ack) begin
                            req_addr <= target;
                        end else begin
                            state <= fetch_squash;
                        end
                    end else if (ack) begin
                        pc       <= next_pc(pc);
                        req_addr <= next_pc(pc);
                        if (slot_free) begin
                            if_pc    <= req_addr;
                            if_inst  <= imem.imem_rdata;
                            if_valid <= 1'b1;
                        end else begin
                            req   <= 1'b0;
                            state <= fetch_buffered;
                        end
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                    end
                end
                fetch_squash: begin
                    if (br) begin
                        pc <= target;
                    end
                    if (!stall) begin
                        if_valid <= 1'b0;
                    end
                    if (ack) begin
                        req_addr <= br ? target : pc;
                        state    <= fetch_req;
                    end
                end
                fetch_buffered: begin
                    if (br) begin
                        pc       <= target;
                        req_addr <= target;
                        if_valid <= 1'b0;
                        req      <= 1'b1;
                        state    <= fetch_req;
                    end else if (!stall && skid_full) begin
                        if_pc    <= skid_pc;
                        if_inst  <= skid_inst;
                        if_valid <= 1'b1;
                        req      <= 1'b1;
                        state    <= fetch_req;
                    end
                end
                default: begin
                    state <= fetch_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - self-checking bench for pc_fetch
module tb_pc_fetch;
    import pc_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = 32'h0;

    logic [31:0] if_pc0, if_inst0, if_pc1, if_inst1;
    logic        if_valid0, if_valid1;

    int checks = 0;
    int errors = 0;

    pc_fetch_if mif0 ();
    pc_fetch_if mif1 ();

    pc_fetch #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
        .branch_target(branch_target), .imem(mif0),
        .if_pc(if_pc0), .if_inst(if_inst0), .if_valid(if_valid0)
    );

    pc_fetch #(.RESET_PC(32'h0000_0200)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
        .branch_target(branch_target), .imem(mif1),
        .if_pc(if_pc1), .if_inst(if_inst1), .if_valid(if_valid1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // memory for dut0: programmable wait states; memory for dut1: zero-wait
    int fixed_wait = 0;
    int rand_w     = 0;
    bit rand_wait  = 0;
    int cnt0       = 0;
    int cur_wait;
    assign cur_wait = rand_wait ? rand_w : fixed_wait;
    assign mif0.imem_ack   = mif0.imem_req && (cnt0 >= cur_wait);
    assign mif0.imem_rdata = mif0.imem_ack ? mem_word(mif0.imem_addr) : 32'hDEAD_BEEF;
    assign mif1.imem_ack   = mif1.imem_req;
    assign mif1.imem_rdata = mif1.imem_ack ? mem_word(mif1.imem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (rst || !mif0.imem_req || mif0.imem_ack) cnt0 <= 0;
        else cnt0 <= cnt0 + 1;
        if (mif0.imem_ack && rand_wait) rand_w <= $urandom_range(0, 2);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // returns at +1 after the edge that starts cycle 0 (first cycle with rst low, state IDLE)
    task automatic do_reset(input bit check_vals);
        @(posedge clk); #1;
        rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = 32'h0;
        @(posedge clk); #1;
        @(negedge clk);
        if (check_vals) begin
            chk1("rst_req0", mif0.imem_req, 1'b0);
            chk ("rst_addr0", mif0.imem_addr, 32'h0);
            chk1("rst_valid0", if_valid0, 1'b0);
            chk ("rst_pc0", if_pc0, 32'h0);
            chk ("rst_inst0", if_inst0, 32'h0);
            chk ("rst_addr1", mif1.imem_addr, 32'h200);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        stall;
        logic        bf;
        logic [31:0] bt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[9];

    logic [31:0] exp_next, prev_addr, prev_pc, prev_inst;
    logic        prev_pend, prev_hold;
    int          consumed;

    initial begin
        // zero-wait, no stall, branch to 0x103 at cycle 5
        tbl[0] = '{0, 0, 32'h0,   0, 32'h000, 0, 32'h0};
        tbl[1] = '{0, 0, 32'h0,   1, 32'h000, 0, 32'h0};
        tbl[2] = '{0, 0, 32'h0,   1, 32'h004, 1, 32'h000};
        tbl[3] = '{0, 0, 32'h0,   1, 32'h008, 1, 32'h004};
        tbl[4] = '{0, 0, 32'h0,   1, 32'h00C, 1, 32'h008};
        tbl[5] = '{0, 1, 32'h103, 1, 32'h010, 1, 32'h00C};
        tbl[6] = '{0, 0, 32'h0,   1, 32'h100, 0, 32'h0};
        tbl[7] = '{0, 0, 32'h0,   1, 32'h104, 1, 32'h100};
        tbl[8] = '{0, 0, 32'h0,   1, 32'h108, 1, 32'h104};

        fixed_wait = 0;
        do_reset(1'b1);
        for (int k = 0; k < 9; k++) begin
            stall = tbl[k].stall; branch_flag = tbl[k].bf; branch_target = tbl[k].bt;
            @(negedge clk);
            chk1($sformatf("tbl%0d_req", k), mif0.imem_req, tbl[k].req);
            chk ($sformatf("tbl%0d_addr", k), mif0.imem_addr, tbl[k].addr);
            chk1($sformatf("tbl%0d_valid", k), if_valid0, tbl[k].valid);
            if (tbl[k].valid) begin
                chk($sformatf("tbl%0d_pc", k), if_pc0, tbl[k].pc);
                chk($sformatf("tbl%0d_inst", k), if_inst0, mem_word(tbl[k].pc));
            end
            @(posedge clk); #1;
        end
        branch_flag = 1'b0;

        // two wait states; branch to 0x40 while 0x10 is outstanding (cycles 13..15)
        fixed_wait = 2;
        do_reset(1'b0);
        for (int c = 0; c <= 19; c++) begin
            branch_flag   = (c == 13);
            branch_target = (c == 13) ? 32'h40 : 32'h0;
            @(negedge clk);
            if (c >= 1 && c <= 13) begin
                chk1($sformatf("ws_req_c%0d", c), mif0.imem_req, 1'b1);
                chk ($sformatf("ws_addr_c%0d", c), mif0.imem_addr, 32'(4 * ((c - 1) / 3)));
                chk1($sformatf("ws_valid_c%0d", c), if_valid0, (c >= 4) && ((c - 4) % 3 == 0));
                if ((c >= 4) && ((c - 4) % 3 == 0))
                    chk($sformatf("ws_pc_c%0d", c), if_pc0, 32'(4 * ((c - 4) / 3)));
            end
            if (c == 14 || c == 15) chk($sformatf("sq_addr_c%0d", c), mif0.imem_addr, 32'h10);
            if (c >= 14 && c <= 18) chk1($sformatf("sq_valid_c%0d", c), if_valid0, 1'b0);
            if (c == 16) chk("sq_next_addr", mif0.imem_addr, 32'h40);
            if (c == 19) begin
                chk1("sq_tgt_valid", if_valid0, 1'b1);
                chk ("sq_tgt_pc", if_pc0, 32'h40);
            end
            @(posedge clk); #1;
        end
        branch_flag = 1'b0;

        // stall for 3 cycles while 0x8 is acked
        fixed_wait = 0;
        do_reset(1'b0);
        for (int c = 0; c <= 8; c++) begin
            stall = (c >= 3 && c <= 5);
            @(negedge clk);
            if (c >= 4 && c <= 6) begin
                chk1($sformatf("stl_req_c%0d", c), mif0.imem_req, 1'b0);
                chk ($sformatf("stl_pc_c%0d", c), if_pc0, 32'h4);
                chk1($sformatf("stl_valid_c%0d", c), if_valid0, 1'b1);
            end
            if (c == 7) begin
                chk("stl_rel_pc", if_pc0, 32'h8);
                chk("stl_rel_inst", if_inst0, mem_word(32'h8));
                chk("stl_rel_addr", mif0.imem_addr, 32'hC);
            end
            if (c == 8) chk("stl_next_pc", if_pc1 - 32'h200, 32'hC);
            @(posedge clk); #1;
        end
        stall = 1'b0;

        // reset pulsed while dut1 (RESET_PC=0x200) sits in BUFFERED
        do_reset(1'b0);
        for (int c = 0; c <= 7; c++) begin
            stall = (c >= 3 && c <= 4);
            rst   = (c == 4);
            @(negedge clk);
            if (c == 4) begin
                chk1("buf_req_dropped", mif1.imem_req, 1'b0);
                chk ("buf_slot_pc", if_pc1, 32'h204);
            end
            if (c == 5) begin
                chk1("rb_req", mif1.imem_req, 1'b0);
                chk ("rb_addr", mif1.imem_addr, 32'h200);
                chk1("rb_valid", if_valid1, 1'b0);
                chk ("rb_pc", if_pc1, 32'h0);
                chk ("rb_inst", if_inst1, 32'h0);
            end
            if (c == 6) begin
                chk1("rb_first_req", mif1.imem_req, 1'b1);
                chk ("rb_first_addr", mif1.imem_addr, 32'h200);
            end
            if (c == 7) chk("rb_first_pc", if_pc1, 32'h200);
            @(posedge clk); #1;
        end
        rst = 1'b0; stall = 1'b0;

        // randomized run against a program-order stream model
        rand_wait = 1;
        do_reset(1'b0);
        exp_next  = 32'h0;
        prev_pend = 1'b0;
        prev_hold = 1'b0;
        prev_addr = 32'h0;
        prev_pc   = 32'h0;
        prev_inst = 32'h0;
        consumed  = 0;
        for (int c = 0; c < 3000; c++) begin
            stall         = ($urandom_range(0, 99) < 30);
            branch_flag   = ($urandom_range(0, 99) < 8);
            branch_target = $urandom;
            @(negedge clk);
            if (prev_pend) begin
                chk1("rnd_req_stable", mif0.imem_req, 1'b1);
                chk ("rnd_addr_stable", mif0.imem_addr, prev_addr);
            end
            if (prev_hold) begin
                chk1("rnd_hold_valid", if_valid0, 1'b1);
                chk ("rnd_hold_pc", if_pc0, prev_pc);
                chk ("rnd_hold_inst", if_inst0, prev_inst);
            end
            if (if_valid0 && !stall) begin
                chk("rnd_stream_pc", if_pc0, exp_next);
                chk("rnd_stream_inst", if_inst0, mem_word(exp_next));
                exp_next = exp_next + 32'd4;
                consumed++;
            end
            if (branch_flag && !stall) exp_next = branch_target & ~32'h3;
            prev_pend = mif0.imem_req && !mif0.imem_ack;
            prev_addr = mif0.imem_addr;
            prev_hold = if_valid0 && stall;
            prev_pc   = if_pc0;
            prev_inst = if_inst0;
            @(posedge clk); #1;
        end
        checks++;
        if (consumed < 200) begin
            errors++;
            $display("FAIL rnd_progress: got %0d instructions expected at least 200", consumed);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
